// File: rtl/ev21g1_fetch_queue.sv
// ev21g1 instruction-fetch front end: issues sequential word reads to program
// memory (1-cycle latency), buffers returned words with their PCs in a
// fall-through prefetch queue, and hands them to decode over valid/ready.
// Supports branch redirect (drops any in-flight response) and a halt level.
module ev21g1_fetch_queue #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           mem_rd,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [INSTR_WIDTH-1:0]         mem_data,
  output logic [INSTR_WIDTH-1:0]         instr,
  output logic [ADDR_WIDTH-1:0]          instr_pc,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  input  logic                           branch_taken,
  input  logic [ADDR_WIDTH-1:0]          branch_target,
  input  logic                           halt,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_WIDTH-1:0] ResetPc = ADDR_WIDTH'(RESET_PC);
  localparam logic [CntW:0] DepthW = (CntW + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    StStart,
    StFetch,
    StHalted
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic                    discard_q, discard_d;
  logic [PtrW-1:0]         head_q, head_d;
  logic [PtrW-1:0]         tail_q, tail_d;

  logic [INSTR_WIDTH-1:0]  data_mem_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_mem_q   [QUEUE_DEPTH];

  logic br;          // effective redirect (ignored while still in StStart)
  logic resp_valid;  // memory response this cycle that is not being discarded
  logic q_empty;
  logic room;
  logic issue;
  logic pop;
  logic store;       // response written into queue storage
  logic deq;         // head removed from queue storage

  // Handshake, issue and queue-control decode.
  always_comb begin
    br         = branch_taken && (state_q != StStart);
    resp_valid = inflight_q && !discard_q;
    q_empty    = (count_q == '0);
    // Reservation: an in-flight read always has a slot waiting for it.
    room       = (({1'b0, count_q} + (CntW + 1)'(inflight_q)) < DepthW);
    issue      = (state_q == StFetch) && !halt && !branch_taken && room;

    instr_valid = !q_empty || resp_valid;
    instr       = '0;
    instr_pc    = '0;
    if (!q_empty) begin
      instr    = data_mem_q[head_q];
      instr_pc = pc_mem_q[head_q];
    end else if (resp_valid) begin
      // Empty queue: the arriving response falls straight through to decode.
      instr    = mem_data;
      instr_pc = inflight_pc_q;
    end

    pop   = instr_valid && instr_ready && !br;
    // A fall-through response consumed this cycle never occupies a slot.
    store = resp_valid && !br && !(q_empty && pop);
    deq   = pop && !q_empty;

    mem_rd      = issue;
    mem_addr    = fetch_pc_q;
    queue_count = count_q;
  end

  // Next-state for pointers, occupancy, fetch PC and in-flight tracking.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    discard_d     = 1'b0;

    if (br) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = branch_target;
      discard_d  = inflight_q;
    end else begin
      if (deq) begin
        head_d = head_q + PtrW'(1);
      end
      if (store) begin
        tail_d = tail_q + PtrW'(1);
      end
      unique case ({store, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(1);
        inflight_pc_d = fetch_pc_q;
      end
    end
  end

  // FSM next-state: one start cycle, then fetch/halt with branch override.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        if (br) begin
          state_d = StFetch;
        end else if (halt) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (br || !halt) begin
          state_d = StFetch;
        end
      end
      default: state_d = StStart;
    endcase
  end

  // Control state registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StStart;
      fetch_pc_q    <= ResetPc;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      discard_q     <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      discard_q     <= discard_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // Queue storage; contents are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    if (store) begin
      data_mem_q[tail_q] <= mem_data;
      pc_mem_q[tail_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_ev21g1_fetch_queue.sv
// Directed bench for ev21g1_fetch_queue: a per-cycle vector table for stream,
// backpressure, halt and branch, plus hand sequences for async reset and
// PC/pointer wrap on a 4-bit-address instance.
module tb_ev21g1_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdy = 1'b0;
  logic        br = 1'b0;
  logic [9:0]  tgt = '0;
  logic        hlt = 1'b0;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data = '0;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic [2:0]  queue_count;

  logic        w_rdy = 1'b0;
  logic        w_mem_rd;
  logic [3:0]  w_mem_addr;
  logic [31:0] w_mem_data = '0;
  logic [31:0] w_instr;
  logic [3:0]  w_instr_pc;
  logic        w_instr_valid;
  logic [2:0]  w_queue_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ev21g1_fetch_queue dut (
    .clk           (clk),
    .reset         (reset),
    .mem_rd        (mem_rd),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (rdy),
    .branch_taken  (br),
    .branch_target (tgt),
    .halt          (hlt),
    .queue_count   (queue_count)
  );

  ev21g1_fetch_queue #(
    .ADDR_WIDTH  (4),
    .INSTR_WIDTH (32),
    .QUEUE_DEPTH (4),
    .RESET_PC    (14)
  ) dut_w (
    .clk           (clk),
    .reset         (reset),
    .mem_rd        (w_mem_rd),
    .mem_addr      (w_mem_addr),
    .mem_data      (w_mem_data),
    .instr         (w_instr),
    .instr_pc      (w_instr_pc),
    .instr_valid   (w_instr_valid),
    .instr_ready   (w_rdy),
    .branch_taken  (1'b0),
    .branch_target (4'd0),
    .halt          (1'b0),
    .queue_count   (w_queue_count)
  );

  // Program memory models: 1-cycle read latency, data = 0xA5A50000 | addr.
  always @(posedge clk) begin
    mem_data   <= 32'hA5A5_0000 | {22'd0, mem_addr};
    w_mem_data <= 32'hA5A5_0000 | {28'd0, w_mem_addr};
  end

  typedef struct {
    logic       rst;
    logic       rdy;
    logic       br;
    logic [9:0] tgt;
    logic       hlt;
    logic       exp_rd;
    logic [9:0] exp_addr;
    logic       chk_head;
    logic       exp_valid;
    logic [9:0] exp_pc;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic r, input logic b, input logic [9:0] t,
                     input logic h, input logic erd, input logic [9:0] eaddr,
                     input logic ch, input logic ev, input logic [9:0] epc,
                     input logic [2:0] ecnt);
    vec_t v;
    v.rst = rst; v.rdy = r; v.br = b; v.tgt = t; v.hlt = h;
    v.exp_rd = erd; v.exp_addr = eaddr; v.chk_head = ch; v.exp_valid = ev;
    v.exp_pc = epc; v.exp_cnt = ecnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rows before the first reset-released cycle start the same way for each run.
  task automatic fill_to_s4_rdy0();
    add(1, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0,  1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1,  1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  1, 2,  1, 1, 0, 1);
  endtask

  logic [7:0] pat = 8'b1101_0001;
  logic [3:0] exp_issue;
  logic [3:0] exp_pop;
  int         issues;
  int         pops;

  initial begin
    // Run A: basic stream with decode always ready.
    add(1, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 1,  1, 1, 0, 0);
    add(0, 1, 0, 0, 0,  1, 2,  1, 1, 1, 0);
    add(0, 1, 0, 0, 0,  1, 3,  1, 1, 2, 0);
    // Run B: backpressure fills exactly four entries, then drains in order.
    fill_to_s4_rdy0();
    add(0, 0, 0, 0, 0,  1, 3,  1, 1, 0, 2);
    add(0, 0, 0, 0, 0,  0, 0,  1, 1, 0, 3);
    add(0, 0, 0, 0, 0,  0, 0,  1, 1, 0, 4);
    add(0, 0, 0, 0, 0,  0, 0,  1, 1, 0, 4);
    add(0, 1, 0, 0, 0,  0, 0,  1, 1, 0, 4);
    add(0, 1, 0, 0, 0,  1, 4,  1, 1, 1, 3);
    add(0, 1, 0, 0, 0,  1, 5,  1, 1, 2, 2);
    add(0, 1, 0, 0, 0,  1, 6,  1, 1, 3, 2);
    add(0, 1, 0, 0, 0,  1, 7,  1, 1, 4, 2);
    add(0, 1, 0, 0, 0,  1, 8,  1, 1, 5, 2);
    // Run C: halt with two queued and one in flight; drain, then resume at 3.
    fill_to_s4_rdy0();
    add(0, 0, 0, 0, 1,  0, 0,  1, 1, 0, 2);
    add(0, 1, 0, 0, 1,  0, 0,  1, 1, 0, 3);
    add(0, 1, 0, 0, 1,  0, 0,  1, 1, 1, 2);
    add(0, 1, 0, 0, 1,  0, 0,  1, 1, 2, 1);
    add(0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 3,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 4,  1, 1, 3, 0);
    // Run D: branch right after addr 5 issues, then branch while halted.
    add(1, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 1,  1, 1, 0, 0);
    add(0, 1, 0, 0, 0,  1, 2,  1, 1, 1, 0);
    add(0, 1, 0, 0, 0,  1, 3,  1, 1, 2, 0);
    add(0, 1, 0, 0, 0,  1, 4,  1, 1, 3, 0);
    add(0, 1, 0, 0, 0,  1, 5,  1, 1, 4, 0);
    add(0, 1, 1, 10'h100, 0,  0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 10'h100,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 10'h101,  1, 1, 10'h100, 0);
    add(0, 1, 0, 0, 0,  1, 10'h102,  1, 1, 10'h101, 0);
    add(0, 1, 1, 10'h200, 1,  0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 1,  0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  0, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  1, 10'h200,  1, 0, 0, 0);
    // Run E: build up to three entries ahead of the async-reset sequence.
    fill_to_s4_rdy0();
    add(0, 0, 0, 0, 0,  1, 3,  1, 1, 0, 2);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst;
      rdy   = vq[i].rdy;
      br    = vq[i].br;
      tgt   = vq[i].tgt;
      hlt   = vq[i].hlt;
      #1;
      chk($sformatf("row%0d mem_rd", i), 32'(mem_rd), 32'(vq[i].exp_rd));
      if (vq[i].exp_rd)
        chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(vq[i].exp_addr));
      if (vq[i].chk_head) begin
        chk($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(vq[i].exp_valid));
        if (vq[i].exp_valid) begin
          chk($sformatf("row%0d instr_pc", i), 32'(instr_pc), 32'(vq[i].exp_pc));
          chk($sformatf("row%0d instr", i), instr, 32'hA5A5_0000 | 32'(vq[i].exp_pc));
        end else begin
          chk($sformatf("row%0d instr_idle", i), instr, 32'd0);
        end
      end
      chk($sformatf("row%0d queue_count", i), 32'(queue_count), 32'(vq[i].exp_cnt));
    end
    br  = 1'b0;
    hlt = 1'b0;

    // Async reset between edges with three entries queued.
    @(posedge clk);
    #2;
    chk("pre_reset count", 32'(queue_count), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_reset valid", 32'(instr_valid), 32'd0);
    chk("async_reset mem_rd", 32'(mem_rd), 32'd0);
    chk("async_reset count", 32'(queue_count), 32'd0);
    chk("async_reset instr", instr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset start mem_rd", 32'(mem_rd), 32'd0);
    @(negedge clk);
    #1;
    chk("post_reset first mem_rd", 32'(mem_rd), 32'd1);
    chk("post_reset first addr", 32'(mem_addr), 32'd0);

    // Wrap: 4-bit PCs from 14, ready pattern forces push/pop overlap and wrap.
    @(negedge clk);
    reset = 1'b1;
    w_rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_issue = 4'd14;
    exp_pop   = 4'd14;
    issues    = 0;
    pops      = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      w_rdy = pat[i % 8];
      #1;
      if (w_mem_rd) begin
        chk($sformatf("wrap issue%0d addr", issues), 32'(w_mem_addr), 32'(exp_issue));
        exp_issue = exp_issue + 4'd1;
        issues++;
      end
      if (w_instr_valid && w_rdy) begin
        chk($sformatf("wrap pop%0d pc", pops), 32'(w_instr_pc), 32'(exp_pop));
        chk($sformatf("wrap pop%0d instr", pops), w_instr, 32'hA5A5_0000 | 32'(exp_pop));
        exp_pop = exp_pop + 4'd1;
        pops++;
      end
      chk($sformatf("wrap cyc%0d count_bound", i), 32'(w_queue_count <= 3'd4), 32'd1);
    end
    chk("wrap pop total", 32'(pops >= 10), 32'd1);
    chk("wrap issue total", 32'(issues >= 14), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ev21g1_fetch_queue.md
Name: ev21g1_fetch_queue

Overview:
Parametrised instruction-fetch front end for the ev21g1 core. It replaces the single-register fetch with a prefetch queue of configurable depth. It issues word reads to program memory (fixed 1-cycle read latency), buffers returned instructions with their PCs, and presents them to decode over a valid/ready handshake. It also supports branch redirect with in-flight discard and a halt mode.

Parameters:
ADDR_WIDTH, 10, program-memory word address width; PC width.
INSTR_WIDTH, 32, instruction word width.
QUEUE_DEPTH, 4, prefetch queue entries; power of two, minimum 2.
RESET_PC, 0, first fetch address after reset.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
mem_rd  out  1  read strobe to program memory.
mem_addr  out  ADDR_WIDTH  read address; valid when mem_rd=1.
mem_data  in  INSTR_WIDTH  read data, valid exactly one cycle after mem_rd.
instr  out  INSTR_WIDTH  queue-head instruction.
instr_pc  out  ADDR_WIDTH  PC of queue-head instruction.
instr_valid  out  1  queue non-empty.
instr_ready  in  1  decode accepts head this cycle.
branch_taken  in  1  redirect request, single-cycle pulse.
branch_target  in  ADDR_WIDTH  redirect address.
halt  in  1  level; stop issuing new fetches.
queue_count  out  clog2(QUEUE_DEPTH)+1  occupied entries, for debug.

Behaviour:
- Reset state:
  - FSM=START, fetch_pc=RESET_PC, count=0, inflight=0, discard=0.
  - Outputs: mem_rd=0, instr_valid=0, instr=0, instr_pc=0, queue_count=0.
- FSM:
  - START -> FETCH unconditionally after one cycle.
  - FETCH -> HALTED when halt=1 and branch_taken=0.
  - HALTED -> FETCH when halt=0.
  - branch_taken in any state other than START forces FETCH, with fetch_pc <= branch_target. If halt is still 1, the FSM goes back to HALTED on the next cycle.
- Issue rule (combinational from registers and inputs):
  - mem_rd = (state==FETCH) && !halt && !branch_taken && (count + inflight < QUEUE_DEPTH).
  - mem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_WIDTH; inflight <= 1; inflight_pc <= fetch_pc.
  - With no issue: inflight <= 0.
- Response: in the cycle after an issue, {inflight_pc, mem_data} is pushed at the tail unless discard=1. The push is guaranteed to have room because inflight was reserved at issue.
- Pop: when instr_valid && instr_ready, the head advances.
  - Simultaneous push and pop leaves count unchanged.
  - Head and tail pointers wrap modulo QUEUE_DEPTH.
- Branch (priority over push, pop and issue):
  - count <= 0, pointers <= 0, fetch_pc <= branch_target.
  - discard <= inflight, so the response arriving next cycle is dropped. discard clears after one cycle.
  - No issue occurs in the branch cycle. The first fetch of the target happens the following cycle.
  - The head is not popped in a branch cycle, even if instr_ready=1.
- Latency:
  - Reset release -> first mem_rd: 1 cycle (START).
  - Issue -> instr_valid: 1 cycle.
  - Branch pulse -> target on instr: 2 cycles.
- Throughput: 1 instruction/cycle sustained while instr_ready=1.
- Full condition: with instr_ready=0, issue stops when count+inflight=QUEUE_DEPTH. The queue holds exactly QUEUE_DEPTH entries and never overflows or drops data.
- Halt: halt only suppresses issue. An in-flight response is still pushed, and decode keeps draining the queue.
- Reset mid-operation: immediate asynchronous return to the reset state. Queue contents and in-flight data are discarded.

Test Plan:
1. Basic stream: memory model data=0xA5A50000|addr, instr_ready=1, release reset → mem_addr issues 0,1,2,... from cycle 1; instr_valid rises cycle 2 with instr=0xA5A50000, instr_pc=0; one new instruction per cycle after that.
2. Backpressure: instr_ready=0 from reset, DEPTH=4 → exactly 4 issues (addr 0-3), mem_rd then stays 0, queue_count=4; raise instr_ready → pops 0,1,2,3 in order, fetch resumes at addr 4 with no gaps or duplicates.
3. Branch with in-flight: pulse branch_taken, target=0x100, in the cycle after addr 5 issues → response for addr 5 is dropped, queue_count=0 next cycle, mem_addr=0x100 next cycle, instr_pc=0x100 valid 2 cycles after the pulse.
4. Halt: assert halt while queue holds 2 entries and 1 is in flight → mem_rd=0, the 3 entries drain to decode; deassert halt → fetch resumes at the next sequential PC.
5. Wrap: ADDR_WIDTH=4, RESET_PC=14 → PCs issued 14,15,0,1; queue pointers wrap correctly over 10+ pushes with simultaneous push/pop.
6. Async reset mid-stream: assert reset between clock edges with queue_count=3 → instr_valid=0 and mem_rd=0 immediately; after release the first fetch is RESET_PC.
